el2_dbg_trigger_csr: RTL and testbench

Debug-trigger CSR bank and hit controller for the EL2 core. Holds four mcontrol-type triggers (`tselect`/`tdata1`/`tdata2`) and drives `trigger_pkt_any[3:0]` to the LSU and IFU trigger matchers. It collects their per-trigger raw match vectors, applies chaining, sets `tdata1.hit`, and raises a registered debug-halt or breakpoint request. It sits in the decode/CSR stage next to the main CSR file.

---
 rtl/el2_dbg_trigger_csr.sv | 162 ++++++++++++++++
 tb/tb_el2_dbg_trigger_csr.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/el2_dbg_trigger_csr.sv
// Debug-trigger CSR bank (tselect/tdata1/tdata2) for four mcontrol triggers with chained hit detection.
// Optional pair chaining enabled by `EL2_DBG_TRIGGER_CHAIN_EN; packet layout per trigger: {select,match,store,load,execute,m,tdata2[31:0]}.
module el2_dbg_trigger_csr (
  input  logic             clk,
  input  logic             rst,
  input  logic             dbg_mode,
  input  logic             csr_wr_en,
  input  logic             csr_rd_en,
  input  logic [11:0]      csr_addr,
  input  logic [31:0]      csr_wrdata,
  output logic [31:0]      csr_rddata,
  output logic             csr_rd_valid,
  output logic [3:0][37:0] trigger_pkt_any,
  input  logic [3:0]       lsu_trigger_match_m,
  input  logic [3:0]       ifu_trigger_match,
  input  logic             trigger_commit,
  output logic [3:0]       trigger_fire_r,
  output logic             trigger_halt_req_r,
  output logic             trigger_brkpt_r
);

  logic [1:0]       tselect_q, tselect_d;
  logic [3:0]       dmode_q, dmode_d, hit_q, hit_d, select_q, select_d;
  logic [3:0]       action_q, action_d, chain_q, chain_d, match_q, match_d;
  logic [3:0]       m_q, m_d, execute_q, execute_d, store_q, store_d, load_q, load_d;
  logic [3:0][31:0] tdata2_q, tdata2_d;
  logic [31:0]      csr_rddata_q, csr_rddata_d;
  logic             csr_rd_valid_q, csr_rd_valid_d;
  logic [3:0]       trigger_fire_q, trigger_fire_d;
  logic             halt_q, halt_d, brkpt_q, brkpt_d;

  logic [3:0]       raw, fire;
  logic [3:0][31:0] tdata1_rd;
  logic             wr_allowed, wr_tdata1, wr_tdata2;

  always_comb begin
    raw = (lsu_trigger_match_m | ifu_trigger_match) & {4{trigger_commit}};
`ifdef EL2_DBG_TRIGGER_CHAIN_EN
    // A chained pair fires together only when both members match in the same commit.
    fire[1:0] = chain_q[0] ? {2{raw[0] & raw[1]}} : raw[1:0];
    fire[3:2] = chain_q[2] ? {2{raw[2] & raw[3]}} : raw[3:2];
`else
    fire = raw;
`endif
  end

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      tdata1_rd[i] = {4'h2, dmode_q[i], 6'd31, hit_q[i], select_q[i], 1'b0, 5'b0,
                      action_q[i], chain_q[i], 3'b0, match_q[i], m_q[i], 3'b0,
                      execute_q[i], store_q[i], load_q[i]};
      trigger_pkt_any[i] = {select_q[i], match_q[i],
                            store_q[i] & m_q[i] & ~dbg_mode,
                            load_q[i] & m_q[i] & ~dbg_mode,
                            execute_q[i] & m_q[i] & ~dbg_mode,
                            m_q[i], tdata2_q[i]};
    end
  end

  always_comb begin
    tselect_d = tselect_q;
    dmode_d   = dmode_q;
    hit_d     = hit_q | fire;
    select_d  = select_q;
    action_d  = action_q;
    chain_d   = chain_q;
    match_d   = match_q;
    m_d       = m_q;
    execute_d = execute_q;
    store_d   = store_q;
    load_d    = load_q;
    tdata2_d  = tdata2_q;

    wr_allowed = ~(dmode_q[tselect_q] & ~dbg_mode);
    wr_tdata1  = csr_wr_en & (csr_addr == 12'h7A1) & wr_allowed;
    wr_tdata2  = csr_wr_en & (csr_addr == 12'h7A2) & wr_allowed;

    if (csr_wr_en && (csr_addr == 12'h7A0) && (csr_wrdata <= 32'd3))
      tselect_d = csr_wrdata[1:0];

    // The CSR write overrides a same-cycle hit on the selected trigger.
    if (wr_tdata1) begin
      dmode_d[tselect_q]   = csr_wrdata[27] & dbg_mode;
      hit_d[tselect_q]     = csr_wrdata[20];
      select_d[tselect_q]  = csr_wrdata[19];
      action_d[tselect_q]  = csr_wrdata[12];
      match_d[tselect_q]   = csr_wrdata[7];
      m_d[tselect_q]       = csr_wrdata[6];
      execute_d[tselect_q] = csr_wrdata[2];
      store_d[tselect_q]   = csr_wrdata[1];
      load_d[tselect_q]    = csr_wrdata[0];
`ifdef EL2_DBG_TRIGGER_CHAIN_EN
      if (!tselect_q[0])
        chain_d[tselect_q] = csr_wrdata[11];
`endif
    end
    if (wr_tdata2)
      tdata2_d[tselect_q] = csr_wrdata;

    csr_rd_valid_d = csr_rd_en;
    csr_rddata_d   = '0;
    if (csr_rd_en) begin
      case (csr_addr)
        12'h7A0: csr_rddata_d = {30'b0, tselect_q};
        12'h7A1: csr_rddata_d = tdata1_rd[tselect_q];
        12'h7A2: csr_rddata_d = tdata2_q[tselect_q];
        default: csr_rddata_d = '0;
      endcase
    end

    trigger_fire_d = fire;
    halt_d         = |(fire & action_q);
    brkpt_d        = |(fire & ~action_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tselect_q      <= '0;
      dmode_q        <= '0;
      hit_q          <= '0;
      select_q       <= '0;
      action_q       <= '0;
      chain_q        <= '0;
      match_q        <= '0;
      m_q            <= '0;
      execute_q      <= '0;
      store_q        <= '0;
      load_q         <= '0;
      tdata2_q       <= '0;
      csr_rddata_q   <= '0;
      csr_rd_valid_q <= 1'b0;
      trigger_fire_q <= '0;
      halt_q         <= 1'b0;
      brkpt_q        <= 1'b0;
    end else begin
      tselect_q      <= tselect_d;
      dmode_q        <= dmode_d;
      hit_q          <= hit_d;
      select_q       <= select_d;
      action_q       <= action_d;
      chain_q        <= chain_d;
      match_q        <= match_d;
      m_q            <= m_d;
      execute_q      <= execute_d;
      store_q        <= store_d;
      load_q         <= load_d;
      tdata2_q       <= tdata2_d;
      csr_rddata_q   <= csr_rddata_d;
      csr_rd_valid_q <= csr_rd_valid_d;
      trigger_fire_q <= trigger_fire_d;
      halt_q         <= halt_d;
      brkpt_q        <= brkpt_d;
    end
  end

  assign csr_rddata         = csr_rddata_q;
  assign csr_rd_valid       = csr_rd_valid_q;
  assign trigger_fire_r     = trigger_fire_q;
  assign trigger_halt_req_r = halt_q;
  assign trigger_brkpt_r    = brkpt_q;

endmodule

// File: tb/tb_el2_dbg_trigger_csr.sv
// Directed bench for el2_dbg_trigger_csr: CSR access, packet gating, hit/chain behaviour, dmode protection.
// Chain-dependent expectations follow `EL2_DBG_TRIGGER_CHAIN_EN.
module tb_el2_dbg_trigger_csr;

  logic             clk = 1'b0;
  logic             rst, dbg_mode, csr_wr_en, csr_rd_en, trigger_commit;
  logic [11:0]      csr_addr;
  logic [31:0]      csr_wrdata, csr_rddata;
  logic             csr_rd_valid;
  logic [3:0][37:0] trigger_pkt_any;
  logic [3:0]       lsu_trigger_match_m, ifu_trigger_match, trigger_fire_r;
  logic             trigger_halt_req_r, trigger_brkpt_r;

  int checks = 0;
  int failures = 0;
  logic [31:0] rd;

  localparam logic [11:0] TSEL = 12'h7A0, TD1 = 12'h7A1, TD2 = 12'h7A2;
  // tdata1 constant fields: type=2, maskmax=31
  localparam logic [31:0] TD1_BASE = 32'h23E0_0000;
  localparam logic [31:0] HIT = 32'h0010_0000;
`ifdef EL2_DBG_TRIGGER_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif

  el2_dbg_trigger_csr dut (
    .clk(clk), .rst(rst), .dbg_mode(dbg_mode),
    .csr_wr_en(csr_wr_en), .csr_rd_en(csr_rd_en), .csr_addr(csr_addr),
    .csr_wrdata(csr_wrdata), .csr_rddata(csr_rddata), .csr_rd_valid(csr_rd_valid),
    .trigger_pkt_any(trigger_pkt_any),
    .lsu_trigger_match_m(lsu_trigger_match_m), .ifu_trigger_match(ifu_trigger_match),
    .trigger_commit(trigger_commit), .trigger_fire_r(trigger_fire_r),
    .trigger_halt_req_r(trigger_halt_req_r), .trigger_brkpt_r(trigger_brkpt_r)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    csr_wr_en = 1'b1; csr_addr = a; csr_wrdata = d;
    step();
    csr_wr_en = 1'b0;
  endtask

  task automatic csr_rd(input logic [11:0] a, output logic [31:0] d);
    csr_rd_en = 1'b1; csr_addr = a;
    step();
    csr_rd_en = 1'b0;
    check("rd_valid", 64'(csr_rd_valid), 64'd1);
    d = csr_rddata;
  endtask

  task automatic hit(input logic [3:0] lsu, input logic [3:0] ifu);
    lsu_trigger_match_m = lsu; ifu_trigger_match = ifu; trigger_commit = 1'b1;
    step();
    lsu_trigger_match_m = '0; ifu_trigger_match = '0; trigger_commit = 1'b0;
  endtask

  initial begin
    rst = 1'b1; dbg_mode = 1'b0; csr_wr_en = 1'b0; csr_rd_en = 1'b0;
    csr_addr = '0; csr_wrdata = '0; trigger_commit = 1'b0;
    lsu_trigger_match_m = '0; ifu_trigger_match = '0;
    step(); step();
    rst = 1'b0;

    check("rst_fire", 64'(trigger_fire_r), 64'd0);
    check("rst_halt_brk", 64'({trigger_halt_req_r, trigger_brkpt_r}), 64'd0);
    check("rst_valid", 64'(csr_rd_valid), 64'd0);
    check("rst_pkt", 64'(trigger_pkt_any[0] | trigger_pkt_any[1] | trigger_pkt_any[2] | trigger_pkt_any[3]), 64'd0);

    csr_rd(TD1, rd);
    check("rst_tdata1", 64'(rd), 64'(TD1_BASE));
    step();
    check("valid_pulse", 64'(csr_rd_valid), 64'd0);
    check("rddata_idle", 64'(csr_rddata), 64'd0);

    csr_wr(TSEL, 32'd5);
    csr_rd(TSEL, rd);
    check("tsel_ign", 64'(rd), 64'd0);
    csr_wr(TSEL, 32'd2);
    csr_rd(TSEL, rd);
    check("tsel_2", 64'(rd), 64'd2);

    // action=1, m=1, store=1 on trigger 2
    csr_wr(TD1, 32'h0000_1042);
    check("pkt2_store", 64'(trigger_pkt_any[2][35]), 64'd1);
    check("pkt2_full", 64'(trigger_pkt_any[2]), 64'h09_0000_0000);
    csr_wr(TD2, 32'hDEAD_BEEF);
    check("pkt2_tdata2", 64'(trigger_pkt_any[2][31:0]), 64'hDEAD_BEEF);
    dbg_mode = 1'b1; #1;
    check("pkt2_dbg_gate", 64'(trigger_pkt_any[2][35]), 64'd0);
    dbg_mode = 1'b0; #1;

    hit(4'b0100, 4'b0000);
    check("t2_fire", 64'(trigger_fire_r), 64'b0100);
    check("t2_halt", 64'(trigger_halt_req_r), 64'd1);
    check("t2_brk", 64'(trigger_brkpt_r), 64'd0);
    csr_rd(TD1, rd);
    check("t2_hit_rd", 64'(rd), 64'(TD1_BASE | HIT | 32'h1042));
    check("fire_pulse", 64'(trigger_fire_r), 64'd0);

    lsu_trigger_match_m = 4'b0100; trigger_commit = 1'b0;
    step();
    lsu_trigger_match_m = '0;
    check("no_commit", 64'(trigger_fire_r), 64'd0);

    // trigger 0: chain, m, execute, action=0
    csr_wr(TSEL, 32'd0);
    csr_wr(TD1, 32'h0000_0844);
    hit(4'b0000, 4'b0001);
    check("t0_alone_fire", 64'(trigger_fire_r), CHAIN ? 64'd0 : 64'b0001);
    check("t0_alone_brk", 64'(trigger_brkpt_r), CHAIN ? 64'd0 : 64'd1);
    hit(4'b0010, 4'b0001);
    check("pair_fire", 64'(trigger_fire_r), 64'b0011);
    check("pair_halt", 64'(trigger_halt_req_r), 64'd0);
    hit(4'b0110, 4'b0001);
    check("both_fire", 64'(trigger_fire_r), 64'b0111);
    check("both_reqs", 64'({trigger_halt_req_r, trigger_brkpt_r}), 64'b11);
    csr_rd(TD1, rd);
    check("t0_rd", 64'(rd), 64'(TD1_BASE | HIT | 32'h44 | (CHAIN ? 32'h800 : 32'h0)));

    csr_wr(TSEL, 32'd1);
    csr_wr(TD1, 32'h0000_0800);
    csr_rd(TD1, rd);
    check("t1_chain_ro", 64'(rd), 64'(TD1_BASE));

    // dmode protection on trigger 3
    csr_wr(TSEL, 32'd3);
    dbg_mode = 1'b1;
    csr_wr(TD1, 32'h0800_0040);
    csr_rd(TD1, rd);
    check("t3_dmode_set", 64'(rd), 64'(TD1_BASE | 32'h0800_0040));
    dbg_mode = 1'b0;
    csr_wr(TD1, 32'h0000_0041);
    csr_wr(TD2, 32'h0000_1234);
    csr_rd(TD1, rd);
    check("t3_wr_ign", 64'(rd), 64'(TD1_BASE | 32'h0800_0040));
    check("t3_td2_ign", 64'(trigger_pkt_any[3][31:0]), 64'd0);

    csr_wr(TSEL, 32'd2);
    csr_wr(TD1, 32'h0800_1042);
    csr_rd(TD1, rd);
    check("dmode_forced0", 64'(rd), 64'(TD1_BASE | 32'h1042));

    // fire and hit-clearing write on trigger 2 in the same cycle
    csr_wr_en = 1'b1; csr_addr = TD1; csr_wrdata = 32'h0000_1042;
    lsu_trigger_match_m = 4'b0100; trigger_commit = 1'b1;
    step();
    csr_wr_en = 1'b0; lsu_trigger_match_m = '0; trigger_commit = 1'b0;
    check("wr_fire", 64'(trigger_fire_r), 64'b0100);
    csr_rd(TD1, rd);
    check("wr_wins_hit", 64'(rd), 64'(TD1_BASE | 32'h1042));

    csr_wr(12'h7A3, 32'hFFFF_FFFF);
    csr_rd(12'h7A3, rd);
    check("unk_rd", 64'(rd), 64'd0);
    csr_rd(TSEL, rd);
    check("unk_no_wr", 64'(rd), 64'd2);

    rst = 1'b1; csr_rd_en = 1'b1; csr_wr_en = 1'b1; csr_addr = TSEL; csr_wrdata = 32'd1;
    step();
    rst = 1'b0; csr_rd_en = 1'b0; csr_wr_en = 1'b0;
    check("rst_rd_valid", 64'(csr_rd_valid), 64'd0);
    check("rst_rd_data", 64'(csr_rddata), 64'd0);
    csr_rd(TSEL, rd);
    check("rst_tsel", 64'(rd), 64'd0);
    csr_rd(TD1, rd);
    check("rst_t0", 64'(rd), 64'(TD1_BASE));
    check("rst_pkt2", 64'(trigger_pkt_any[2]), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
